// File: rtl/ssd_capture_pkg.sv
// Shared constants for the seven-segment capture path: segment codes, anode selects, FSM states.
package ssd_capture_pkg;

  localparam int SSD_RATE_W = 16;

  // Active-low segment patterns {g,f,e,d,c,b,a} for nibbles 0..F, shared with the encoder side
  localparam logic [6:0] SSD_SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [3:0] SSD_AN_D0  = 4'b1110;
  localparam logic [3:0] SSD_AN_D1  = 4'b1101;
  localparam logic [3:0] SSD_AN_D2  = 4'b1011;
  localparam logic [3:0] SSD_AN_D3  = 4'b0111;
  localparam logic [3:0] SSD_AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SSD_CAP_IDLE  = 2'd0,
    SSD_CAP_TRACK = 2'd1,
    SSD_CAP_HOLD  = 2'd2
  } ssd_cap_state_t;

  // Returns {exactly_one_low, digit_index}
  function automatic logic [2:0] anode_decode(input logic [3:0] an);
    case (an)
      SSD_AN_D0: anode_decode = 3'b100;
      SSD_AN_D1: anode_decode = 3'b101;
      SSD_AN_D2: anode_decode = 3'b110;
      SSD_AN_D3: anode_decode = 3'b111;
      default:   anode_decode = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment to nibble decoder; valid is low for codes outside the hex table.
module ssd_seg_decode
  import ssd_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  logic [15:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (seg == SSD_SEG_CODE[gi]);
    end
  endgenerate

  // Table entries are distinct, so at most one hit bit is set
  always_comb begin
    valid  = |hit;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) nibble = 4'(i);
    end
  end

endmodule

// File: rtl/ssd_capture.sv
// Samples a scanned 4-digit SSD bus and rebuilds the displayed hex frame.
// Optional SSD_CAPTURE_DP_EN adds dp_bits (lit decimal points per digit).
module ssd_capture
  import ssd_capture_pkg::*;
#(
  parameter int RATE_W = SSD_RATE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] stable,
  input  logic              clr,
  input  logic [3:0]        anode,
  input  logic [6:0]        seg,
  input  logic              dp,
  output logic [15:0]       digits,
  output logic              frame_valid,
  output logic [3:0]        bad_mask,
  output logic              err_anode,
  output logic              err_seg
`ifdef SSD_CAPTURE_DP_EN
  ,
  output logic [3:0]        dp_bits
`endif
);

  logic [3:0]        s_anode, p_anode;
  logic [6:0]        s_seg, p_seg;
  logic              s_dp, p_dp;
  ssd_cap_state_t    state;
  logic [RATE_W-1:0] count;
  logic [15:0]       shadow;
  logic [3:0]        bad_shadow, mask;
  logic [3:0]        mask_next, bad_next;
  logic [RATE_W-1:0] thr_m1;
  logic              changed, at_thr, eval, capture, one_low, multi_low, frame_done;
  logic [1:0]        idx;
  logic              dec_valid;
  logic [3:0]        dec_nib;

  ssd_seg_decode u_dec (
    .seg    (s_seg),
    .valid  (dec_valid),
    .nibble (dec_nib)
  );

  assign changed    = {s_anode, s_seg, s_dp} != {p_anode, p_seg, p_dp};
  assign thr_m1     = (stable == '0) ? '0 : stable - RATE_W'(1);
  // >= so that lowering stable below the running count still fires
  assign at_thr     = (count >= thr_m1);
  assign eval       = (state == SSD_CAP_TRACK) && !changed && at_thr;
  assign {one_low, idx} = anode_decode(s_anode);
  assign multi_low  = (s_anode != SSD_AN_OFF) && !one_low;
  assign capture    = eval && one_low;
  assign frame_done = (mask == 4'hF);

  always_comb begin
    mask_next = frame_done ? 4'h0 : mask;
    bad_next  = frame_done ? 4'h0 : bad_shadow;
    if (capture) begin
      mask_next[idx] = 1'b1;
      bad_next[idx]  = !dec_valid;
    end
    if (clr) begin
      mask_next = 4'h0;
      bad_next  = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_anode     <= SSD_AN_OFF;
      p_anode     <= SSD_AN_OFF;
      s_seg       <= 7'h7F;
      p_seg       <= 7'h7F;
      s_dp        <= 1'b1;
      p_dp        <= 1'b1;
      state       <= SSD_CAP_IDLE;
      count       <= '0;
      shadow      <= '0;
      bad_shadow  <= '0;
      mask        <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      bad_mask    <= '0;
      err_anode   <= 1'b0;
      err_seg     <= 1'b0;
    end else begin
      s_anode <= anode;
      s_seg   <= seg;
      s_dp    <= dp;
      p_anode <= s_anode;
      p_seg   <= s_seg;
      p_dp    <= s_dp;

      if (changed) begin
        count <= '0;
        state <= SSD_CAP_TRACK;
      end else if (state == SSD_CAP_TRACK) begin
        if (at_thr) begin
          state <= (s_anode == SSD_AN_OFF) ? SSD_CAP_IDLE : SSD_CAP_HOLD;
        end else if (count != '1) begin
          count <= count + RATE_W'(1);
        end
      end

      if (capture) shadow[idx*4 +: 4] <= dec_valid ? dec_nib : 4'h0;
      mask       <= mask_next;
      bad_shadow <= bad_next;

      err_seg   <= !clr && (err_seg   || (capture && !dec_valid));
      err_anode <= !clr && (err_anode || (eval && multi_low));

      frame_valid <= frame_done;
      if (frame_done) begin
        digits   <= shadow;
        bad_mask <= bad_shadow;
      end
    end
  end

`ifdef SSD_CAPTURE_DP_EN
  logic [3:0] dp_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_shadow <= '0;
      dp_bits   <= '0;
    end else begin
      if (capture) dp_shadow[idx] <= !s_dp;
      if (frame_done) dp_bits <= dp_shadow;
    end
  end
`endif

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture: directed scans push expected frames, a monitor checks each pulse.
module tb_ssd_capture;
  import ssd_capture_pkg::*;

  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] stable = RW'(4);
  logic          clr = 1'b0;
  logic [3:0]    anode = SSD_AN_OFF;
  logic [6:0]    seg = 7'h7F;
  logic          dp = 1'b1;
  logic [15:0]   digits;
  logic          frame_valid;
  logic [3:0]    bad_mask;
  logic          err_anode;
  logic          err_seg;
`ifdef SSD_CAPTURE_DP_EN
  logic [3:0]    dp_bits;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;
  logic [19:0] exp_q[$];

  ssd_capture #(.RATE_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stable      (stable),
    .clr         (clr),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .digits      (digits),
    .frame_valid (frame_valid),
    .bad_mask    (bad_mask),
    .err_anode   (err_anode),
    .err_seg     (err_seg)
`ifdef SSD_CAPTURE_DP_EN
    ,
    .dp_bits     (dp_bits)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every frame pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      logic [19:0] e;
      n_cmp++;
      n_frames++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_frame: got digits=%h bad=%b, required no pulse", digits, bad_mask);
      end else begin
        e = exp_q.pop_front();
        if ({digits, bad_mask} !== e) begin
          n_bad++;
          $display("FAIL frame%0d: got digits=%h bad=%b, required digits=%h bad=%b",
                   n_frames, digits, bad_mask, e[19:4], e[3:0]);
        end else begin
          $display("frame%0d: digits=%h bad=%b ok", n_frames, digits, bad_mask);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("%s: %h ok", name, act);
    end
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    anode = a;
    seg   = s;
    dp    = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] c3, input logic [6:0] c2, input logic [6:0] c1,
                       input logic [6:0] c0, input int n);
    show(SSD_AN_D3, c3, n);
    show(SSD_AN_D2, c2, n);
    show(SSD_AN_D1, c1, n);
    show(SSD_AN_D0, c0, n);
    show(SSD_AN_OFF, 7'h7F, 4);
  endtask

  // Bounded wait for the monitor to consume all queued frames
  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d frames outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("reset_digits", digits, 16'h0);
    check("reset_frame_valid", 16'(frame_valid), 16'h0);
    check("reset_bad_mask", 16'(bad_mask), 16'h0);
    check("reset_err_anode", 16'(err_anode), 16'h0);
    check("reset_err_seg", 16'(err_seg), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    show(SSD_AN_OFF, 7'h7F, 3);

    // Basic scan of 0x1A3F
    stable = RW'(4);
    exp_q.push_back({16'h1A3F, 4'b0000});
    scan4(7'h79, 7'h08, 7'h30, 7'h0E, 10);
    drain("scan_1a3f");

    // Two-cycle glitch on digit1 shorter than the stability window
    exp_q.push_back({16'h1A3F, 4'b0000});
    show(SSD_AN_D3, 7'h79, 10);
    show(SSD_AN_D2, 7'h08, 10);
    show(SSD_AN_D1, 7'h00, 2);
    show(SSD_AN_D1, 7'h30, 10);
    show(SSD_AN_D0, 7'h0E, 10);
    show(SSD_AN_OFF, 7'h7F, 4);
    drain("glitch");

    // Blank code on digit2
    exp_q.push_back({16'h103F, 4'b0100});
    scan4(7'h79, 7'h7F, 7'h30, 7'h0E, 10);
    drain("undecodable");
    check("err_seg_set", 16'(err_seg), 16'h1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("err_seg_clr", 16'(err_seg), 16'h0);

    // Two anodes low: error only, no frame expected
    show(4'b1100, 7'h40, 10);
    show(SSD_AN_OFF, 7'h7F, 10);
    check("err_anode_set", 16'(err_anode), 16'h1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("err_anode_clr", 16'(err_anode), 16'h0);

    // Reset after three captured digits must discard the partial frame
    show(SSD_AN_D2, 7'h12, 10);
    show(SSD_AN_D1, 7'h12, 10);
    show(SSD_AN_D0, 7'h12, 10);
    show(SSD_AN_OFF, 7'h7F, 2);
    rst = 1'b1;
    #2;
    check("async_reset_digits", digits, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    show(SSD_AN_D3, 7'h00, 10);
    show(SSD_AN_D2, 7'h00, 10);
    show(SSD_AN_D1, 7'h00, 10);
    exp_q.push_back({16'h8888, 4'b0000});
    show(SSD_AN_D0, 7'h00, 10);
    show(SSD_AN_OFF, 7'h7F, 4);
    drain("post_reset");

    // stable=0 acts as 1; two-cycle dwell is the shortest giving one equal comparison
    stable = RW'(0);
    exp_q.push_back({16'h0123, 4'b0000});
    scan4(7'h40, 7'h79, 7'h24, 7'h30, 2);
    drain("stable_zero");

    check("frame_count", 16'(n_frames), 16'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
